fht_addr_gen: RTL and testbench
===============================

# fht_addr_gen

Address and control sequencer for the in-place-free (ping-pong) radix-2 FHT core. It walks all N_LOG2 stages of an N-point transform and issues one butterfly per clock. Each issue produces three data-RAM read addresses and a twiddle-ROM index, which feed the butterfly's X0/X1/X2 and SIN/COS inputs. It also produces the matching write-back addresses and enables, delayed to line up with the butterfly outputs Y0/Y1. Bit-reversed loading of the input and unloading of the result are done outside this block.

## Interface
- N_LOG2, 4: log2 of transform length N (N ≥ 4).
- A_BIT, N_LOG2: data RAM address width.
- PIPE_LAT, 3: read-to-write latency in clocks (1 RAM/ROM read + 2 butterfly).
- iCLK  in  1  clock; all state changes on rising edge.
- iRESET  in  1  reset, synchronous, active-low.
- iSTART  in  1  start request, sampled only in IDLE.
- oBUSY  out  1  high while a transform is in progress.
- oDONE  out  1  one-cycle pulse after the last write of the last stage.
- oSTAGE  out  $clog2(N_LOG2)  current stage s, 0..N_LOG2-1.
- oBANK  out  1  read bank for the current stage (= s[0]); the write bank is ~oBANK.
- oRD_EN  out  1  read strobe for RAM and ROM.
- oRD_ADDR_0 / oRD_ADDR_1 / oRD_ADDR_2  out  A_BIT each  addresses feeding X0 / X1 / X2.
- oTW_ADDR  out  N_LOG2-1  twiddle index t; the ROM returns cos/sin(2πt/N).
- oWR_EN  out  1  write strobe for Y0/Y1.
- oWR_ADDR_0 / oWR_ADDR_1  out  A_BIT each  destinations of Y0 / Y1.

## Operation
- FSM states and transitions:
  - IDLE: iSTART=1 → RUN with s=0, j=0.
  - RUN: issue one butterfly per cycle for j = 0..N/2-1, then go to DRAIN.
  - DRAIN: oRD_EN=0 for PIPE_LAT cycles. Then, if s < N_LOG2-1, increment s and return to RUN with j=0; otherwise go to DONE.
  - DONE: one cycle, then IDLE.
- Address generation within stage s, with h = 2^s:
  - k = j mod h; g = (j / h)·2h.
  - oRD_ADDR_0 = g+k.
  - oRD_ADDR_1 = g+h+k.
  - oRD_ADDR_2 = g+h+((h−k) mod h).
  - oTW_ADDR = k << (N_LOG2−1−s).
  - All arithmetic is unsigned and modulo 2^A_BIT. No value ever exceeds N−1.
- Write-back: oWR_EN, oWR_ADDR_0 (= read addr 0) and oWR_ADDR_1 (= read addr 1) are the read-side values delayed by exactly PIPE_LAT cycles through a shift pipeline.
- The bank toggles only at the DRAIN→RUN transition. Every write in flight therefore lands in ~oBANK of the stage that issued it.
- Stage 0 reads bank 0. The final result lands in bank ~((N_LOG2−1)[0]), which is bank 0 for N_LOG2=4.
- iSTART is ignored in RUN, DRAIN and DONE.
- Reset: when iRESET=0 at an edge, the block goes to IDLE. All outputs and the delay pipeline are cleared to 0, so in-flight writes are discarded. This applies mid-transform as well.

## Timing
- All outputs are registered. Reset value of every output is 0.
- If iSTART is sampled at edge E0, the first RUN cycle is the cycle after E0:
  - oBUSY=1 from that cycle;
  - oRD_EN=1 with j=0 addresses in that cycle.
- Cycles per stage: N/2 + PIPE_LAT.
- Total oBUSY cycles: N_LOG2·(N/2+PIPE_LAT).
- oDONE is high in the single cycle after the final oWR_EN cycle. oBUSY=0 in that cycle.
- The earliest next iSTART is accepted in the first IDLE cycle after DONE.
- The next stage's first read comes one cycle after the previous stage's last write, so read-after-write through the RAM is safe.

## Test plan
All scenarios use N_LOG2=4, PIPE_LAT=3, with cycle numbers counted from the cycle after iSTART is sampled (cycle 1).
- Reset held 5 cycles, then released → all outputs 0. FSM stays in IDLE until iSTART.
- iSTART pulse, stage 0 →
  - cycle 1: oRD_EN=1, addresses (0,1,1), oTW_ADDR=0, oBANK=0.
  - cycle 2: addresses (2,3,3).
  - cycle 8: addresses (14,15,15).
  - cycles 9–11: oRD_EN=0.
- Stage 2 (cycles 23–30), j=1 → addresses (1,5,7), oTW_ADDR=2, oBANK=0, oSTAGE=2. Stage 3, j=3 → addresses (3,11,13), oTW_ADDR=3, oBANK=1.
- Write alignment →
  - oWR_EN first high at cycle 4 with (0,1); last stage-0 write at cycle 11.
  - Stage-1 reads start at cycle 12 with oBANK=1.
  - The monitor checks every write equals the read issued 3 cycles earlier.
- Completion → oBUSY high cycles 1–44; last oWR_EN at cycle 44; oDONE=1 only at cycle 45. An iSTART pulsed at cycle 20 has no effect.
- Reset mid-run: iRESET=0 at cycle 20 → all outputs 0 on the next cycle and no further oWR_EN. A new iSTART reproduces the cycle-1 values exactly.

Source files
------------

// File: rtl/fht_addr_gen_if.sv
// rtl/fht_addr_gen_if.sv - start request plus read/twiddle/write-back address bus of the FHT sequencer
interface fht_addr_gen_if #(
  parameter int N_LOG2 = 4,
  parameter int A_BIT  = N_LOG2
);
  logic                      iSTART;
  logic                      oBUSY;
  logic                      oDONE;
  logic [$clog2(N_LOG2)-1:0] oSTAGE;
  logic                      oBANK;
  logic                      oRD_EN;
  logic [A_BIT-1:0]          oRD_ADDR_0;
  logic [A_BIT-1:0]          oRD_ADDR_1;
  logic [A_BIT-1:0]          oRD_ADDR_2;
  logic [N_LOG2-2:0]         oTW_ADDR;
  logic                      oWR_EN;
  logic [A_BIT-1:0]          oWR_ADDR_0;
  logic [A_BIT-1:0]          oWR_ADDR_1;

  modport master (
    input  iSTART,
    output oBUSY, oDONE, oSTAGE, oBANK, oRD_EN, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2,
           oTW_ADDR, oWR_EN, oWR_ADDR_0, oWR_ADDR_1
  );

  modport slave (
    output iSTART,
    input  oBUSY, oDONE, oSTAGE, oBANK, oRD_EN, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2,
           oTW_ADDR, oWR_EN, oWR_ADDR_0, oWR_ADDR_1
  );
endinterface

// File: rtl/fht_addr_gen.sv
// rtl/fht_addr_gen.sv - stage/butterfly sequencer for the ping-pong radix-2 FHT core
module fht_addr_gen #(
  parameter int N_LOG2   = 4,
  parameter int A_BIT    = N_LOG2,
  parameter int PIPE_LAT = 3
) (
  input logic           iCLK,
  input logic           iRESET,
  fht_addr_gen_if.master bus
);
  localparam int SW   = $clog2(N_LOG2);
  localparam int JW   = N_LOG2 - 1;
  localparam int DW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int HALF = 1 << JW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [JW-1:0]   j, j_n;
  logic [DW-1:0]   dcnt, dcnt_n;

  logic [A_BIT-1:0] jx, h, k, g;
  logic             busy_n, done_n, rd_en_n;
  logic [A_BIT-1:0] addr0_n, addr1_n, addr2_n;
  logic [JW-1:0]    tw_n;

  logic             wr_en_pipe [PIPE_LAT];
  logic [A_BIT-1:0] wr0_pipe   [PIPE_LAT];
  logic [A_BIT-1:0] wr1_pipe   [PIPE_LAT];

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state <= IDLE;
      s     <= '0;
      j     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      s     <= s_n;
      j     <= j_n;
      dcnt  <= dcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    j_n     = j;
    dcnt_n  = dcnt;
    case (state)
      IDLE: begin
        if (bus.iSTART) begin
          state_n = RUN;
          s_n     = '0;
          j_n     = '0;
        end
      end
      RUN: begin
        if (j == JW'(HALF - 1)) begin
          state_n = DRAIN;
          dcnt_n  = '0;
        end else begin
          j_n = j + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt == DW'(PIPE_LAT - 1)) begin
          if (s == SW'(N_LOG2 - 1)) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
            s_n     = s + 1'b1;
            j_n     = '0;
          end
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        s_n     = '0;
      end
    endcase
  end

  // Outputs are computed from the next-state values so they can be registered
  // and still show the j=0 addresses in the first RUN cycle.
  always_comb begin
    busy_n  = (state_n == RUN) || (state_n == DRAIN);
    done_n  = (state_n == DONE);
    rd_en_n = (state_n == RUN);
    jx      = A_BIT'(j_n);
    h       = A_BIT'(1) << s_n;
    k       = jx & (h - A_BIT'(1));
    g       = ((jx >> s_n) << s_n) << 1;
    addr0_n = '0;
    addr1_n = '0;
    addr2_n = '0;
    tw_n    = '0;
    if (rd_en_n) begin
      addr0_n = g + k;
      addr1_n = g + h + k;
      addr2_n = g + h + ((h - k) & (h - A_BIT'(1)));
      tw_n    = JW'(k) << (SW'(N_LOG2 - 1) - s_n);
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      bus.oBUSY      <= 1'b0;
      bus.oDONE      <= 1'b0;
      bus.oSTAGE     <= '0;
      bus.oBANK      <= 1'b0;
      bus.oRD_EN     <= 1'b0;
      bus.oRD_ADDR_0 <= '0;
      bus.oRD_ADDR_1 <= '0;
      bus.oRD_ADDR_2 <= '0;
      bus.oTW_ADDR   <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        wr_en_pipe[i] <= 1'b0;
        wr0_pipe[i]   <= '0;
        wr1_pipe[i]   <= '0;
      end
    end else begin
      bus.oBUSY      <= busy_n;
      bus.oDONE      <= done_n;
      bus.oSTAGE     <= s_n;
      bus.oBANK      <= s_n[0];
      bus.oRD_EN     <= rd_en_n;
      bus.oRD_ADDR_0 <= addr0_n;
      bus.oRD_ADDR_1 <= addr1_n;
      bus.oRD_ADDR_2 <= addr2_n;
      bus.oTW_ADDR   <= tw_n;
      wr_en_pipe[0]  <= bus.oRD_EN;
      wr0_pipe[0]    <= bus.oRD_ADDR_0;
      wr1_pipe[0]    <= bus.oRD_ADDR_1;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wr_en_pipe[i] <= wr_en_pipe[i-1];
        wr0_pipe[i]   <= wr0_pipe[i-1];
        wr1_pipe[i]   <= wr1_pipe[i-1];
      end
    end
  end

  // Write-back is the registered read side delayed by PIPE_LAT clocks.
  assign bus.oWR_EN     = wr_en_pipe[PIPE_LAT-1];
  assign bus.oWR_ADDR_0 = wr0_pipe[PIPE_LAT-1];
  assign bus.oWR_ADDR_1 = wr1_pipe[PIPE_LAT-1];
endmodule

// File: tb/tb_fht_addr_gen.sv
// tb/tb_fht_addr_gen.sv - directed vector bench for fht_addr_gen (N_LOG2=4, PIPE_LAT=3)
module tb_fht_addr_gen;
  localparam int N_LOG2   = 4;
  localparam int A_BIT    = 4;
  localparam int PIPE_LAT = 3;
  localparam int NCYC     = 47;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  fht_addr_gen_if #(.N_LOG2(N_LOG2), .A_BIT(A_BIT)) bus ();

  fht_addr_gen #(.N_LOG2(N_LOG2), .A_BIT(A_BIT), .PIPE_LAT(PIPE_LAT)) dut (
    .iCLK  (clk),
    .iRESET(rstn),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int rd_en; int a0; int a1; int a2; int tw; int bank; int stage;
    int wr_en; int w0; int w1; int busy; int done;
  } vec_t;

  typedef struct {
    int rd_en; int a0; int a1; int a2; int tw;
  } rd_t;

  int r_rd_en [NCYC+1], r_a0 [NCYC+1], r_a1 [NCYC+1], r_a2 [NCYC+1], r_tw [NCYC+1];
  int r_bank  [NCYC+1], r_stage [NCYC+1], r_wr_en [NCYC+1], r_w0 [NCYC+1], r_w1 [NCYC+1];
  int r_busy  [NCYC+1], r_done [NCYC+1];

  task automatic chk(input string name, input int cyc, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference read side: each stage is 8 issue cycles then 3 drain cycles.
  function automatic rd_t model_rd(input int c);
    rd_t r;
    int st, pos, hh, kk, gg;
    r = '{default: 0};
    if (c >= 1 && c <= 44) begin
      st  = (c - 1) / 11;
      pos = (c - 1) % 11;
      if (pos < 8) begin
        hh      = 1 << st;
        kk      = pos % hh;
        gg      = (pos / hh) * 2 * hh;
        r.rd_en = 1;
        r.a0    = gg + kk;
        r.a1    = gg + hh + kk;
        r.a2    = gg + hh + ((hh - kk) % hh);
        r.tw    = kk * (8 / hh);
      end
    end
    return r;
  endfunction

  task automatic record(input int c);
    r_rd_en[c] = int'(bus.oRD_EN);
    r_a0[c]    = int'(bus.oRD_ADDR_0);
    r_a1[c]    = int'(bus.oRD_ADDR_1);
    r_a2[c]    = int'(bus.oRD_ADDR_2);
    r_tw[c]    = int'(bus.oTW_ADDR);
    r_bank[c]  = int'(bus.oBANK);
    r_stage[c] = int'(bus.oSTAGE);
    r_wr_en[c] = int'(bus.oWR_EN);
    r_w0[c]    = int'(bus.oWR_ADDR_0);
    r_w1[c]    = int'(bus.oWR_ADDR_1);
    r_busy[c]  = int'(bus.oBUSY);
    r_done[c]  = int'(bus.oDONE);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  0, int'(bus.oBUSY),      0);
    chk({tag, "_done"},  0, int'(bus.oDONE),      0);
    chk({tag, "_stage"}, 0, int'(bus.oSTAGE),     0);
    chk({tag, "_bank"},  0, int'(bus.oBANK),      0);
    chk({tag, "_rd_en"}, 0, int'(bus.oRD_EN),     0);
    chk({tag, "_rd0"},   0, int'(bus.oRD_ADDR_0), 0);
    chk({tag, "_rd1"},   0, int'(bus.oRD_ADDR_1), 0);
    chk({tag, "_rd2"},   0, int'(bus.oRD_ADDR_2), 0);
    chk({tag, "_tw"},    0, int'(bus.oTW_ADDR),   0);
    chk({tag, "_wr_en"}, 0, int'(bus.oWR_EN),     0);
    chk({tag, "_wr0"},   0, int'(bus.oWR_ADDR_0), 0);
    chk({tag, "_wr1"},   0, int'(bus.oWR_ADDR_1), 0);
  endtask

  // Returns positioned at the negedge inside cycle 1.
  task automatic start_pulse();
    @(negedge clk);
    bus.iSTART = 1'b1;
    @(negedge clk);
    bus.iSTART = 1'b0;
  endtask

  initial begin
    vec_t vecs [$];
    rd_t  m, mw;

    vecs.push_back('{1,  1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{2,  1, 2, 3, 3, 0, 0, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{4,  1, 6, 7, 7, 0, 0, 0, 1, 0, 1, 1, 0});
    vecs.push_back('{8,  1, 14, 15, 15, 0, 0, 0, 1, 8, 9, 1, 0});
    vecs.push_back('{9,  0, 0, 0, 0, 0, 0, 0, 1, 10, 11, 1, 0});
    vecs.push_back('{11, 0, 0, 0, 0, 0, 0, 0, 1, 14, 15, 1, 0});
    vecs.push_back('{12, 1, 0, 2, 2, 0, 1, 1, 0, 0, 0, 1, 0});
    vecs.push_back('{13, 1, 1, 3, 3, 4, 1, 1, 0, 0, 0, 1, 0});
    vecs.push_back('{24, 1, 1, 5, 7, 2, 0, 2, 0, 0, 0, 1, 0});
    vecs.push_back('{37, 1, 3, 11, 13, 3, 1, 3, 1, 0, 8, 1, 0});
    vecs.push_back('{39, 1, 5, 13, 11, 5, 1, 3, 1, 2, 10, 1, 0});
    vecs.push_back('{44, 0, 0, 0, 0, 0, 1, 3, 1, 7, 15, 1, 0});

    bus.iSTART = 1'b0;
    rstn       = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_zero("reset");
    repeat (3) @(negedge clk);
    chk("idle_busy", 0, int'(bus.oBUSY), 0);
    chk("idle_rd_en", 0, int'(bus.oRD_EN), 0);

    // Full transform, with an iSTART during cycle 20 that must be ignored.
    start_pulse();
    record(1);
    for (int c = 2; c <= NCYC; c++) begin
      @(negedge clk);
      bus.iSTART = (c == 20);
      record(c);
    end
    bus.iSTART = 1'b0;

    foreach (vecs[i]) begin
      automatic int c = vecs[i].cyc;
      chk("vec_rd_en", c, r_rd_en[c], vecs[i].rd_en);
      chk("vec_rd0",   c, r_a0[c],    vecs[i].a0);
      chk("vec_rd1",   c, r_a1[c],    vecs[i].a1);
      chk("vec_rd2",   c, r_a2[c],    vecs[i].a2);
      chk("vec_tw",    c, r_tw[c],    vecs[i].tw);
      chk("vec_bank",  c, r_bank[c],  vecs[i].bank);
      chk("vec_stage", c, r_stage[c], vecs[i].stage);
      chk("vec_wr_en", c, r_wr_en[c], vecs[i].wr_en);
      chk("vec_wr0",   c, r_w0[c],    vecs[i].w0);
      chk("vec_wr1",   c, r_w1[c],    vecs[i].w1);
      chk("vec_busy",  c, r_busy[c],  vecs[i].busy);
      chk("vec_done",  c, r_done[c],  vecs[i].done);
    end

    for (int c = 1; c <= NCYC; c++) begin
      m  = model_rd(c);
      mw = model_rd(c - PIPE_LAT);
      chk("run_rd_en", c, r_rd_en[c], m.rd_en);
      chk("run_rd0",   c, r_a0[c],    m.a0);
      chk("run_rd1",   c, r_a1[c],    m.a1);
      chk("run_rd2",   c, r_a2[c],    m.a2);
      chk("run_tw",    c, r_tw[c],    m.tw);
      chk("run_wr_en", c, r_wr_en[c], mw.rd_en);
      chk("run_wr0",   c, r_w0[c],    mw.a0);
      chk("run_wr1",   c, r_w1[c],    mw.a1);
      chk("run_busy",  c, r_busy[c],  (c <= 44) ? 1 : 0);
      chk("run_done",  c, r_done[c],  (c == 45) ? 1 : 0);
      if (c <= 44) begin
        chk("run_stage", c, r_stage[c], (c - 1) / 11);
        chk("run_bank",  c, r_bank[c],  ((c - 1) / 11) % 2);
      end
    end

    // Reset in the middle of stage 1, then restart from scratch.
    start_pulse();
    for (int c = 2; c <= 20; c++) @(negedge clk);
    chk("pre_reset_busy", 20, int'(bus.oBUSY), 1);
    rstn = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("after_reset_wr_en", 22 + c, int'(bus.oWR_EN), 0);
      chk("after_reset_busy",  22 + c, int'(bus.oBUSY),  0);
    end
    start_pulse();
    chk("restart_rd_en", 1, int'(bus.oRD_EN),     1);
    chk("restart_busy",  1, int'(bus.oBUSY),      1);
    chk("restart_rd0",   1, int'(bus.oRD_ADDR_0), 0);
    chk("restart_rd1",   1, int'(bus.oRD_ADDR_1), 1);
    chk("restart_rd2",   1, int'(bus.oRD_ADDR_2), 1);
    chk("restart_tw",    1, int'(bus.oTW_ADDR),   0);
    chk("restart_bank",  1, int'(bus.oBANK),      0);
    chk("restart_wr_en", 1, int'(bus.oWR_EN),     0);
    repeat (3) @(negedge clk);
    chk("restart_wr_en4", 4, int'(bus.oWR_EN),     1);
    chk("restart_wr1_4",  4, int'(bus.oWR_ADDR_1), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
